bus_trap_monitor: RTL



---
 rtl/bus_trap_monitor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bus_trap_monitor.sv
// ---------------------------------------------------------------------------
// bus_trap_monitor
//
// Passive observer on the 6502 CPU bus. Watches opcode fetches and declares
// the self-test finished when the CPU keeps fetching the same instruction
// address (JMP * / branch-to-self). It reports pass when that address equals
// SUCCESS_ADDR. It reports timeout when the opcode-fetch budget runs out
// before any trap is seen. It drives nothing on the bus.
//
// Parameters
//   SUCCESS_ADDR  trap PC that means the test passed
//   REPEAT_COUNT  consecutive fetches at one address that declare a trap (2..15)
//   MAX_INSTR     opcode-fetch budget before timeout; 0 disables the timeout
//
// Ports
//   i_clk          system clock (same clock as the CPU)
//   i_reset_n      asynchronous active-low reset
//   i_phi2         CPU phase-2; the bus cycle is valid while high
//   i_sync         opcode-fetch indicator
//   i_addr[15:0]   CPU bus address
//   i_rw           1 = read
//   i_data[7:0]    bus read data
//   o_done         sticky: finished (trap or timeout)
//   o_pass         sticky: trapped at SUCCESS_ADDR
//   o_timeout      sticky: budget exhausted without a trap
//   o_trap_pc      trap address, or last fetch address on timeout
//   o_instr_count  opcode fetches counted, saturating
//
// Build option
//   BUS_TRAP_MONITOR_OPCODE_CHECK_EN  when defined, a same-address fetch
//   counts as a repeat only if its opcode can loop to itself: JMP abs (4C)
//   or a relative branch.
// ---------------------------------------------------------------------------
module bus_trap_monitor #(
    parameter logic [15:0] SUCCESS_ADDR = 16'h3469,
    parameter int unsigned REPEAT_COUNT = 3,
    parameter logic [31:0] MAX_INSTR    = 32'd100_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_phi2,
    input  logic        i_sync,
    input  logic [15:0] i_addr,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic [15:0] o_trap_pc,
    output logic [31:0] o_instr_count
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DONE_TRAP = 2'd1,
        ST_DONE_TO   = 2'd2
    } state_t;

    localparam logic [3:0] REP_TARGET = REPEAT_COUNT[3:0];

    // Bus-cycle capture
    logic        r_phi2_q;
    logic        r_cap_sync;
    logic [15:0] r_cap_addr;
    logic        r_cap_rw;
    logic [7:0]  r_cap_data;

    // Monitor state
    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_last_pc;
    logic        r_last_valid;
    logic [3:0]  r_rep_cnt;
    logic [31:0] r_instr_cnt;
    logic        r_pass;
    logic [15:0] r_trap_pc;

    // Combinational helpers
    logic        w_eval;
    logic        w_fetch;
    logic        w_opcode_ok;
    logic        w_same_pc;
    logic [3:0]  w_rep_next;
    logic [31:0] w_cnt_next;
    logic        w_trap_hit;
    logic        w_to_hit;

    // ------------------------------------------------------------------
    // Capture: keep sampling while phi2 is high. The last sample taken
    // before phi2 drops is the settled bus cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phi2_q   <= 1'b0;
            r_cap_sync <= 1'b0;
            r_cap_addr <= 16'h0000;
            r_cap_rw   <= 1'b0;
            r_cap_data <= 8'h00;
        end else begin
            r_phi2_q <= i_phi2;
            if (i_phi2) begin
                r_cap_sync <= i_sync;
                r_cap_addr <= i_addr;
                r_cap_rw   <= i_rw;
                r_cap_data <= i_data;
            end
        end
    end

    // Evaluate on the phi2 falling edge. Only sync reads are opcode fetches.
    // Once a DONE state is reached, fetches are ignored so the counter freezes.
    assign w_eval  = r_phi2_q & ~i_phi2;
    assign w_fetch = w_eval & r_cap_sync & r_cap_rw & (r_state == ST_RUN);

`ifdef BUS_TRAP_MONITOR_OPCODE_CHECK_EN
    // The relative branches 10,30,...,F0 all share the low five bits 10000.
    assign w_opcode_ok = (r_cap_data == 8'h4C) || (r_cap_data[4:0] == 5'b10000);
`else
    // The opcode is not used in this build. Folding it into a signal that
    // nothing reads keeps the capture register in one place for both builds.
    logic w_data_unused;
    assign w_data_unused = ^r_cap_data;
    assign w_opcode_ok   = 1'b1;
`endif

    // The valid flag stops the first fetch after reset from matching a
    // stale last_pc of 0000.
    assign w_same_pc  = r_last_valid && (r_cap_addr == r_last_pc) && w_opcode_ok;
    assign w_rep_next = !w_same_pc          ? 4'd1 :
                        (r_rep_cnt == 4'hF) ? 4'hF : (r_rep_cnt + 4'd1);
    assign w_cnt_next = (r_instr_cnt == 32'hFFFF_FFFF) ? r_instr_cnt
                                                       : (r_instr_cnt + 32'd1);
    assign w_trap_hit = (w_rep_next == REP_TARGET);
    assign w_to_hit   = (MAX_INSTR != 32'd0) && (w_cnt_next == MAX_INSTR);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A trap takes priority over a timeout on the same fetch.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_fetch) begin
            if (w_trap_hit) begin
                w_state_next = ST_DONE_TRAP;
            end else if (w_to_hit) begin
                w_state_next = ST_DONE_TO;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers, advanced on each qualifying fetch while running
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last_pc    <= 16'h0000;
            r_last_valid <= 1'b0;
            r_rep_cnt    <= 4'd1;
            r_instr_cnt  <= 32'd0;
            r_pass       <= 1'b0;
            r_trap_pc    <= 16'h0000;
        end else if (w_fetch) begin
            r_last_pc    <= r_cap_addr;
            r_last_valid <= 1'b1;
            r_rep_cnt    <= w_rep_next;
            r_instr_cnt  <= w_cnt_next;
            if (w_trap_hit) begin
                r_trap_pc <= r_cap_addr;
                r_pass    <= (r_cap_addr == SUCCESS_ADDR);
            end else if (w_to_hit) begin
                r_trap_pc <= r_cap_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        o_done        = (r_state != ST_RUN);
        o_timeout     = (r_state == ST_DONE_TO);
        o_pass        = r_pass;
        o_trap_pc     = r_trap_pc;
        o_instr_count = r_instr_cnt;
    end

endmodule
